// File: rtl/alu_seq_nbit_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle MIPS ALU.
package alu_seq_nbit_pkg;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_MULTU = 3'b011,
    ALU_DIVU  = 3'b100,
    ALU_NOR   = 3'b101,
    ALU_SUB   = 3'b110,
    ALU_SLT   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // Two's-complement overflow from the operand signs and the sum sign; b is the post-inversion operand.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b_eff,
                                        input logic sign_sum);
    return (sign_a == sign_b_eff) && (sign_sum != sign_a);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// Exposes the next-step values so the caller can register the final step directly.
module alu_muldiv_iter
  import alu_seq_nbit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             finished_o,
  output logic [WIDTH-1:0] lo_next_o,
  output logic [WIDTH-1:0] hi_next_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_n_s, lo_n_s;

  // One iteration: mul adds the multiplicand when lo[0] is set then shifts right;
  // div shifts the next dividend bit into the remainder and subtracts if it fits.
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {hi_q, lo_q[WIDTH-1]};
    div_ge_s   = div_sh_s[WIDTH] || (div_sh_s[WIDTH-1:0] >= opnd_q);
    div_diff_s = div_sh_s[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      hi_n_s = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
      lo_n_s = {lo_q[WIDTH-2:0], div_ge_s};
    end else begin
      hi_n_s = mul_sum_s[WIDTH:1];
      lo_n_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load captures operands (divisor/multiplicand in opnd, dividend/multiplier in lo).
  always_comb begin
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      div_d  = div_i;
      opnd_d = div_i ? b_i : a_i;
      lo_d   = div_i ? a_i : b_i;
      hi_d   = {WIDTH{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
    end else if (step_i) begin
      hi_d  = hi_n_s;
      lo_d  = lo_n_s;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd_q <= {WIDTH{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      div_q  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign finished_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign lo_next_o  = lo_n_s;
  assign hi_next_o  = hi_n_s;

endmodule

// File: rtl/alu_seq_nbit.sv
// N-bit multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU
// behind a start/done handshake, with all outputs registered.
module alu_seq_nbit
  import alu_seq_nbit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  alu_op_e          op_s;
  logic             is_sub_s, iter_op_s;
  logic [WIDTH-1:0] b_eff_s, sum_s, sc_lo_s, sc_hi_s;
  logic             sc_ovf_s, sc_dbz_s;
  logic             load_s, step_s, iter_last_s;
  logic [WIDTH-1:0] iter_lo_s, iter_hi_s;

  assign op_s = alu_op_e'(ALUop);

  // Single-cycle results; DIVU by zero is folded in here since it never iterates.
  always_comb begin
    is_sub_s  = (op_s == ALU_SUB);
    b_eff_s   = is_sub_s ? ~input2 : input2;
    sum_s     = input1 + b_eff_s + {{(WIDTH-1){1'b0}}, is_sub_s};
    iter_op_s = (op_s == ALU_MULTU) || ((op_s == ALU_DIVU) && (input2 != {WIDTH{1'b0}}));
    sc_lo_s   = {WIDTH{1'b0}};
    sc_hi_s   = {WIDTH{1'b0}};
    sc_ovf_s  = 1'b0;
    sc_dbz_s  = 1'b0;
    case (op_s)
      ALU_AND: sc_lo_s = input1 & input2;
      ALU_OR:  sc_lo_s = input1 | input2;
      ALU_NOR: sc_lo_s = ~(input1 | input2);
      ALU_ADD, ALU_SUB: begin
        sc_lo_s  = sum_s;
        sc_ovf_s = add_overflow(input1[WIDTH-1], b_eff_s[WIDTH-1], sum_s[WIDTH-1]);
      end
      ALU_SLT: sc_lo_s = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      ALU_DIVU: begin
        sc_lo_s  = {WIDTH{1'b1}};
        sc_hi_s  = input1;
        sc_dbz_s = 1'b1;
      end
      default: sc_lo_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state and output-register next values; outputs hold while EXEC runs.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    load_s   = 1'b0;
    step_s   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && iter_op_s) begin
          state_d = S_EXEC;
          load_s  = 1'b1;
        end else if (start) begin
          state_d  = S_DONE;
          result_d = sc_lo_s;
          hi_d     = sc_hi_s;
          zero_d   = (sc_lo_s == {WIDTH{1'b0}});
          ovf_d    = sc_ovf_s;
          dbz_d    = sc_dbz_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        step_s = 1'b1;
        if (iter_last_s) begin
          state_d  = S_DONE;
          result_d = iter_lo_s;
          hi_d     = iter_hi_s;
          zero_d   = (iter_lo_s == {WIDTH{1'b0}});
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .step_i     (step_s),
    .div_i      (op_s == ALU_DIVU),
    .a_i        (input1),
    .b_i        (input2),
    .finished_o (iter_last_s),
    .lo_next_o  (iter_lo_s),
    .hi_next_o  (iter_hi_s)
  );

  assign result      = result_q;
  assign result_hi   = hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
